// File: rtl/window_3x3_assembler.sv
// -----------------------------------------------------------------------------
// window_3x3_assembler
//
// Purpose:
//   Sits at the consumer end of a three-row line buffer. Each accepted pixel
//   strobe delivers one column of taps (rows r, r-1, r-2). This block shifts
//   that column into a 3x3 window, tracks the frame position, and flags only
//   windows that lie entirely inside the frame. It feeds the 3x3 kernels
//   (Sobel, Gaussian, NMS) of the edge-detection pipeline.
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high reset
//   clken         in   pixel strobe, taps valid this cycle
//   frame_start   in   high together with clken on pixel (0,0)
//   taps0x        in   pixel (r,   c)
//   taps1x        in   pixel (r-1, c)
//   taps2x        in   pixel (r-2, c)
//   m11..m33      out  window, mRC: R=1 oldest row, C=1 oldest column
//   matrix_valid  out  one-cycle flag per fully interior window
//   center_x      out  centre column of the valid window
//   center_y      out  centre row of the valid window
//   frame_done    out  one-cycle pulse after the last pixel of a frame
//   frame_err     out  sticky, frame_start seen in the middle of a frame
// -----------------------------------------------------------------------------
module window_3x3_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] taps0x,
  input  logic [DATA_WIDTH-1:0] taps1x,
  input  logic [DATA_WIDTH-1:0] taps2x,
  output logic [DATA_WIDTH-1:0] m11,
  output logic [DATA_WIDTH-1:0] m12,
  output logic [DATA_WIDTH-1:0] m13,
  output logic [DATA_WIDTH-1:0] m21,
  output logic [DATA_WIDTH-1:0] m22,
  output logic [DATA_WIDTH-1:0] m23,
  output logic [DATA_WIDTH-1:0] m31,
  output logic [DATA_WIDTH-1:0] m32,
  output logic [DATA_WIDTH-1:0] m33,
  output logic                  matrix_valid,
  output logic [XW-1:0]         center_x,
  output logic [YW-1:0]         center_y,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam logic [XW-1:0] LAST_X = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(IMG_HEIGHT - 1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;

  logic          w_accept;
  logic          w_resync;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_last;
  logic          w_interior;

  logic [DATA_WIDTH-1:0] r_win_p1 [3][3];
  logic                  r_vld_p1;
  logic [XW-1:0]         r_cx_p1;
  logic [YW-1:0]         r_cy_p1;
  logic                  r_done_p1;
  logic                  r_err;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last)   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: acceptance and position of the pixel on the taps this cycle.
  // A frame_start pixel is always (0,0), whether it opens a frame from IDLE
  // or forces a resync in the middle of one.
  always_comb begin
    w_accept   = clken && ((r_state == S_ACTIVE) || frame_start);
    w_resync   = clken && frame_start && (r_state == S_ACTIVE);
    w_x        = frame_start ? '0 : r_col;
    w_y        = frame_start ? '0 : r_row;
    w_last     = w_accept && (w_x == LAST_X) && (w_y == LAST_Y);
    w_interior = w_accept && (w_x >= XW'(2)) && (w_y >= YW'(2));
  end

  // Position counters point at the next pixel expected; they return to (0,0)
  // after the last pixel so an idle block is ready for the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_x == LAST_X) begin
        r_col <= '0;
        r_row <= (w_y == LAST_Y) ? '0 : w_y + YW'(1);
      end else begin
        r_col <= w_x + XW'(1);
        r_row <= w_y;
      end
    end
  end

  // Stage p1: window shift, column 3 takes the new taps (row 1 = oldest row)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win_p1[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win_p1[i][0] <= r_win_p1[i][1];
        r_win_p1[i][1] <= r_win_p1[i][2];
      end
      r_win_p1[0][2] <= taps2x;
      r_win_p1[1][2] <= taps1x;
      r_win_p1[2][2] <= taps0x;
    end
  end

  // Stage p1: status and centre coordinates, aligned with the window
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_cx_p1   <= '0;
      r_cy_p1   <= '0;
      r_done_p1 <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vld_p1  <= w_interior;
      r_done_p1 <= w_last;
      r_err     <= r_err | w_resync;
      if (w_interior) begin
        r_cx_p1 <= w_x - XW'(1);
        r_cy_p1 <= w_y - YW'(1);
      end
    end
  end

  assign m11 = r_win_p1[0][0];
  assign m12 = r_win_p1[0][1];
  assign m13 = r_win_p1[0][2];
  assign m21 = r_win_p1[1][0];
  assign m22 = r_win_p1[1][1];
  assign m23 = r_win_p1[1][2];
  assign m31 = r_win_p1[2][0];
  assign m32 = r_win_p1[2][1];
  assign m33 = r_win_p1[2][2];

  assign matrix_valid = r_vld_p1;
  assign center_x     = r_cx_p1;
  assign center_y     = r_cy_p1;
  assign frame_done   = r_done_p1;
  assign frame_err    = r_err;

endmodule

// File: tb/tb_window_3x3_assembler.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_assembler
//
// Bench for window_3x3_assembler on an 8x6 frame. Stimulus tasks play whole
// images column by column; the reference model works from the image itself:
// every accepted interior pixel (r,c) yields the 3x3 block img[r-2..r][c-2..c]
// with centre (c-1, r-1). A monitor records what the DUT emits; each test
// task compares the recorded stream against the model inline.
// -----------------------------------------------------------------------------
module tb_window_3x3_assembler;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef struct packed {
    logic [XW-1:0]   cx;
    logic [YW-1:0]   cy;
    logic [9*DW-1:0] win;  // {m11,m12,m13,m21,m22,m23,m31,m32,m33}
  } win_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clken = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] taps0x = '0, taps1x = '0, taps2x = '0;
  logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
  logic          matrix_valid;
  logic [XW-1:0] center_x;
  logic [YW-1:0] center_y;
  logic          frame_done;
  logic          frame_err;

  window_3x3_assembler #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .XW(XW), .YW(YW)
  ) dut (
    .clock(clock), .reset(reset), .clken(clken), .frame_start(frame_start),
    .taps0x(taps0x), .taps1x(taps1x), .taps2x(taps2x),
    .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
    .m31(m31), .m32(m32), .m33(m33),
    .matrix_valid(matrix_valid), .center_x(center_x), .center_y(center_y),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   gap_viol = 0;
  bit   in_frame = 0;
  bit   exp_err = 0;
  logic [DW-1:0] img [H][W];
  win_t exp_q[$];
  win_t obs_q[$];
  int   exp_done_q[$];
  int   obs_done_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: sample outputs 2 time units after the active edge.
  always @(posedge clock) begin
    #2;
    if (matrix_valid === 1'b1) begin
      obs_q.push_back(win_t'({center_x, center_y, m11, m12, m13, m21, m22, m23, m31, m32, m33}));
      if (clken !== 1'b1) gap_viol++;
    end
    if (frame_done === 1'b1) obs_done_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic fill_img(input bit ramp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ramp ? DW'(16 * r + c) : DW'($urandom);
  endtask

  // Drive one pixel of the current image and advance the reference model.
  task automatic put_px(input int r, input int c, input bit fs);
    win_t e;
    @(negedge clock);
    clken       = 1'b1;
    frame_start = fs;
    taps0x      = img[r][c];
    taps1x      = (r >= 1) ? img[(r >= 1) ? r - 1 : 0][c] : DW'($urandom);
    taps2x      = (r >= 2) ? img[(r >= 2) ? r - 2 : 0][c] : DW'($urandom);
    if (in_frame || fs) begin
      if (fs && in_frame) exp_err = 1'b1;
      if (r >= 2 && c >= 2) begin
        e.cx = XW'(c - 1);
        e.cy = YW'(r - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[(8 - (i * 3 + j)) * DW +: DW] = img[r - 2 + i][c - 2 + j];
        exp_q.push_back(e);
      end
      if (r == H - 1 && c == W - 1) begin
        in_frame = 1'b0;
        exp_done_q.push_back(cyc + 1);
      end else begin
        in_frame = 1'b1;
      end
    end
  endtask

  // Gap cycles carry random taps and a random frame_start; all must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      clken       = 1'b0;
      frame_start = 1'($urandom);
      taps0x      = DW'($urandom);
      taps1x      = DW'($urandom);
      taps2x      = DW'($urandom);
    end
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input int gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        put_px(r, c, (r == 0 && c == 0));
        if (gaps > 0) idle(gaps);
      end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset       = 1'b1;
    clken       = 1'b1;
    frame_start = 1'b1;
    taps0x      = DW'($urandom);
    @(negedge clock);
    reset       = 1'b0;
    clken       = 1'b0;
    frame_start = 1'b0;
    in_frame    = 1'b0;
    exp_err     = 1'b0;
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    obs_q.delete();
    exp_done_q.delete();
    obs_done_q.delete();
    gap_viol = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({m11, m12, m13, m21, m22, m23, m31, m32, m33} !== '0)
      $display("FAIL reset_window: got %h required 0", {m11, m12, m13, m21, m22, m23, m31, m32, m33});
    else pass_cnt++;
    total_cnt++;
    if (matrix_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", matrix_valid);
    else pass_cnt++;
    total_cnt++;
    if ({center_x, center_y} !== '0) $display("FAIL reset_center: got x=%0d y=%0d required 0,0", center_x, center_y);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b required 0", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL reset_err: got %b required 0", frame_err);
    else pass_cnt++;
    idle(2);
    clear_scoreboard();
  endtask

  task automatic test_continuous();
    win_t f, l;
    fill_img(1'b1);
    run_frame(0);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== 24) $display("FAIL cont_count: got %0d required 24", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL cont_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    f = (obs_q.size() > 0) ? obs_q[0] : '0;
    l = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
    total_cnt++;
    if (f.cx !== 3'd1 || f.cy !== 3'd1 || f.win[71:64] !== 8'h00 || f.win[55:48] !== 8'h02 ||
        f.win[23:16] !== 8'h20 || f.win[7:0] !== 8'h22)
      $display("FAIL cont_first: got x=%0d y=%0d w=%h required x=1 y=1 m11=00 m13=02 m31=20 m33=22",
               f.cx, f.cy, f.win);
    else pass_cnt++;
    total_cnt++;
    if (l.cx !== 3'd6 || l.cy !== 3'd4 || l.win[7:0] !== 8'h57)
      $display("FAIL cont_last: got x=%0d y=%0d m33=%h required x=6 y=4 m33=57", l.cx, l.cy, l.win[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (obs_done_q.size() !== 1 || exp_done_q.size() !== 1 || obs_done_q[0] !== exp_done_q[0])
      $display("FAIL cont_done: got %0d pulses first@%0d required 1 pulse @%0d", obs_done_q.size(),
               (obs_done_q.size() > 0) ? obs_done_q[0] : -1, (exp_done_q.size() > 0) ? exp_done_q[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== exp_err) $display("FAIL cont_err: got %b required %b", frame_err, exp_err);
    else pass_cnt++;
    clear_scoreboard();
  endtask

  task automatic test_gated();
    fill_img(1'b0);
    run_frame(2);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL gated_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL gated_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    total_cnt++;
    if (gap_viol !== 0) $display("FAIL gated_gap_valid: got %0d valid gap cycles required 0", gap_viol);
    else pass_cnt++;
    total_cnt++;
    if (obs_done_q.size() !== 1 || obs_done_q[0] !== exp_done_q[0])
      $display("FAIL gated_done: got %0d pulses required 1 @%0d", obs_done_q.size(), exp_done_q[0]);
    else pass_cnt++;
    clear_scoreboard();
  endtask

  task automatic test_idle_pulses();
    fill_img(1'b1);
    for (int k = 0; k < 6; k++) begin
      put_px($urandom_range(H - 1, 2), $urandom_range(W - 1, 2), 1'b0);
      idle(1);
    end
    total_cnt++;
    if (obs_q.size() !== 0 || obs_done_q.size() !== 0)
      $display("FAIL idle_ignored: got %0d windows %0d done required 0 0", obs_q.size(), obs_done_q.size());
    else pass_cnt++;
    run_frame(0);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL idle_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL idle_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    clear_scoreboard();
  endtask

  task automatic test_back_to_back();
    fill_img(1'b0);
    run_frame(0);
    fill_img(1'b0);
    run_frame(0);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== 48) $display("FAIL b2b_count: got %0d required 48", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL b2b_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL b2b_err: got %b required 0", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (obs_done_q.size() !== 2) $display("FAIL b2b_done: got %0d pulses required 2", obs_done_q.size());
    else pass_cnt++;
    clear_scoreboard();
  endtask

  task automatic test_resync();
    win_t n;
    fill_img(1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 4) put_px(r, c, (r == 0 && c == 0));
    fill_img(1'b0);
    put_px(0, 0, 1'b1);
    put_px(0, 1, 1'b0);
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL resync_err_set: got %b required 1", frame_err);
    else pass_cnt++;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r > 0 || c > 1) put_px(r, c, 1'b0);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== 32) $display("FAIL resync_count: got %0d required 32", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL resync_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    n = (obs_q.size() > 8) ? obs_q[8] : '0;
    total_cnt++;
    if (n.cx !== 3'd1 || n.cy !== 3'd1)
      $display("FAIL resync_first_center: got x=%0d y=%0d required x=1 y=1", n.cx, n.cy);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== exp_err || exp_err !== 1'b1) $display("FAIL resync_err_sticky: got %b required 1", frame_err);
    else pass_cnt++;
    clear_scoreboard();
  endtask

  task automatic test_reset_mid();
    fill_img(1'b0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c <= 5) put_px(r, c, (r == 0 && c == 0));
    apply_reset();
    total_cnt++;
    if ({m11, m12, m13, m21, m22, m23, m31, m32, m33, matrix_valid, center_x, center_y, frame_done, frame_err} !== '0)
      $display("FAIL rstmid_zero: got w=%h v=%b x=%0d y=%0d d=%b e=%b required all 0",
               {m11, m12, m13, m21, m22, m23, m31, m32, m33}, matrix_valid, center_x, center_y, frame_done, frame_err);
    else pass_cnt++;
    for (int k = 0; k < 10; k++) put_px(3 + (k % 3), 2 + (k % 6), 1'b0);
    idle(2);
    total_cnt++;
    if (obs_q.size() !== 4 || obs_done_q.size() !== 0)
      $display("FAIL rstmid_ignored: got %0d windows %0d done required 4 0", obs_q.size(), obs_done_q.size());
    else pass_cnt++;
    fill_img(1'b0);
    run_frame(1);
    idle(3);
    total_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      win_t o;
      o = (i < obs_q.size()) ? obs_q[i] : '0;
      total_cnt++;
      if (o !== exp_q[i])
        $display("FAIL rstmid_win[%0d]: got x=%0d y=%0d w=%h required x=%0d y=%0d w=%h",
                 i, o.cx, o.cy, o.win, exp_q[i].cx, exp_q[i].cy, exp_q[i].win);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_done_q.size() !== 1 || frame_err !== 1'b0)
      $display("FAIL rstmid_done_err: got %0d done err=%b required 1 done err=0", obs_done_q.size(), frame_err);
    else pass_cnt++;
    clear_scoreboard();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gated();
    test_idle_pulses();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
